// File: rtl/mult_pkg.sv
// Shared constants for the shift-add multiplier.
//   S_IDLE/S_RUN/S_DONE : control state encodings
//   MULT_W              : default operand width
package mult_pkg;

    localparam int unsigned MULT_W = 32;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    typedef enum logic [1:0] {
        StIdle = S_IDLE,
        StRun  = S_RUN,
        StDone = S_DONE
    } state_e;

endpackage

// File: rtl/mult_add_shift_dp.sv
// Add-shift datapath: accumulator/multiplicand registers and the adder.
//   clk    : clock, rising edge
//   rst    : synchronous active-high clear of acc and mc
//   ld     : load acc low half with mplier and capture mcand
//   sh     : perform one conditional add plus right shift
//   mplier : multiplier operand
//   mcand  : multiplicand operand
//   hi, lo : upper and lower product words
module mult_add_shift_dp
    import mult_pkg::*;
#(
    parameter int unsigned W = MULT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ld,
    input  logic         sh,
    input  logic [W-1:0] mplier,
    input  logic [W-1:0] mcand,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo
);

    // One extra bit above the product so the adder carry survives the shift.
    logic [2*W:0] acc_q;
    logic [W-1:0] mc_q;
    logic [W:0]   sum;

    // acc_q[2W] is always zero when an add happens, so including it is harmless.
    always_comb begin
        sum = acc_q[2*W:W] + {1'b0, (acc_q[0] ? mc_q : {W{1'b0}})};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            mc_q  <= '0;
        end else if (ld) begin
            acc_q <= {{(W+1){1'b0}}, mplier};
            mc_q  <= mcand;
        end else if (sh) begin
            acc_q <= {1'b0, sum, acc_q[W-1:1]};
        end
    end

    assign hi = acc_q[2*W-1:W];
    assign lo = acc_q[W-1:0];

endmodule

// File: rtl/mult_shift_add.sv
// Sequential unsigned shift-add multiplier (control FSM + datapath).
// Works with an external counter that is cleared while load is high and
// raises k once it has counted W add-shift cycles.
//   clk           : clock, rising edge
//   rst           : synchronous active-high reset
//   st            : start request, only honoured in idle
//   mplier, mcand : operands, captured on an accepted start
//   k             : counter has reached W
//   load          : holds the counter cleared (high in idle and done)
//   busy          : high in run and done
//   done          : one-cycle pulse, product valid
//   hi, lo        : product words, held until the next accepted start
module mult_shift_add
    import mult_pkg::*;
#(
    parameter int unsigned W = MULT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         st,
    input  logic [W-1:0] mplier,
    input  logic [W-1:0] mcand,
    input  logic         k,
    output logic         load,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo
);

    state_e state_q;
    logic   ld;
    logic   sh;

    // Outputs are registered alongside the state so they track it exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            load    <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (st) begin
                        state_q <= StRun;
                        load    <= 1'b0;
                        busy    <= 1'b1;
                    end
                    done <= 1'b0;
                end
                StRun: begin
                    if (k) begin
                        state_q <= StDone;
                        load    <= 1'b1;
                        done    <= 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    load    <= 1'b1;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    load    <= 1'b1;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

    // The final cycle with k high neither adds nor shifts.
    always_comb begin
        ld = (state_q == StIdle) && st;
        sh = (state_q == StRun) && !k;
    end

    mult_add_shift_dp #(
        .W (W)
    ) u_dp (
        .clk    (clk),
        .rst    (rst),
        .ld     (ld),
        .sh     (sh),
        .mplier (mplier),
        .mcand  (mcand),
        .hi     (hi),
        .lo     (lo)
    );

endmodule

// File: tb/tb_mult_shift_add.sv
module tb_mult_shift_add;
    import mult_pkg::*;

    localparam int unsigned W = MULT_W;

    logic         clk = 1'b0;
    logic         rst;
    logic         st;
    logic [W-1:0] mplier;
    logic [W-1:0] mcand;
    logic         k;
    logic         load;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic [7:0]   cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Counter beside the multiplier: cleared by load, K when count == W.
    always_ff @(posedge clk) begin
        if (load) cnt <= '0;
        else      cnt <= cnt + 8'd1;
    end
    assign k = (cnt == 8'(W));

    mult_shift_add #(
        .W (W)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .st     (st),
        .mplier (mplier),
        .mcand  (mcand),
        .k      (k),
        .load   (load),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Start one multiply; optionally re-pulse st with other operands at inject_at.
    task automatic run_op(input logic [W-1:0] mp, input logic [W-1:0] mc, input int inject_at,
                          input logic [W-1:0] mp2, input logic [W-1:0] mc2,
                          output int edges, output int low, output int npulse,
                          output logic [W-1:0] rhi, output logic [W-1:0] rlo,
                          output logic rbusy);
        @(negedge clk);
        st = 1'b1; mplier = mp; mcand = mc;
        edges = 0; low = 0; npulse = 0; rhi = '0; rlo = '0; rbusy = 1'b0;
        while (edges < 100) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            st = 1'b0;
            if (edges == inject_at) begin
                st = 1'b1; mplier = mp2; mcand = mc2;
            end
            if (!load) low++;
            if (done) begin
                npulse++; rhi = hi; rlo = lo; rbusy = busy;
                break;
            end
        end
        repeat (3) begin
            @(negedge clk);
            if (done) npulse++;
        end
    endtask

    typedef struct {
        logic [W-1:0] mp;
        logic [W-1:0] mc;
        logic [W-1:0] exp_hi;
        logic [W-1:0] exp_lo;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int edges, low, npulse, d, pulses;
        logic [W-1:0] rhi, rlo;
        logic rbusy;

        vecs[0] = '{32'd3, 32'd5, 32'h0, 32'd15};
        vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[2] = '{32'h0, 32'h12345678, 32'h0, 32'h0};
        vecs[3] = '{32'h1, 32'h12345678, 32'h0, 32'h12345678};
        vecs[4] = '{32'h80000000, 32'h2, 32'h1, 32'h0};
        vecs[5] = '{32'hDEADBEEF, 32'h10, 32'hD, 32'hEADBEEF0};

        rst = 1'b1; st = 1'b0; mplier = '0; mcand = '0;
        repeat (2) @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_load", 64'(load), 64'd1);
        check("reset_hi",   64'(hi),   64'd0);
        check("reset_lo",   64'(lo),   64'd0);
        rst = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) begin
            run_op(vecs[i].mp, vecs[i].mc, -1, '0, '0, edges, low, npulse, rhi, rlo, rbusy);
            check($sformatf("v%0d_latency", i), 64'(edges), 64'(W + 2));
            check($sformatf("v%0d_hi", i), 64'(rhi), 64'(vecs[i].exp_hi));
            check($sformatf("v%0d_lo", i), 64'(rlo), 64'(vecs[i].exp_lo));
            check($sformatf("v%0d_pulses", i), 64'(npulse), 64'd1);
            check($sformatf("v%0d_busy_at_done", i), 64'(rbusy), 64'd1);
            check($sformatf("v%0d_hold_lo", i), 64'(lo), 64'(vecs[i].exp_lo));
            if (i == 0) check("v0_load_low_cycles", 64'(low), 64'(W + 1));
        end

        // St re-pulsed with different operands during RUN must be ignored.
        run_op(32'd3, 32'd5, 10, 32'd100, 32'd100, edges, low, npulse, rhi, rlo, rbusy);
        check("ignore_st_latency", 64'(edges), 64'(W + 2));
        check("ignore_st_lo", 64'(rlo), 64'd15);
        check("ignore_st_hi", 64'(rhi), 64'd0);
        check("ignore_st_pulses", 64'(npulse), 64'd1);

        // Reset in the middle of RUN aborts and clears the result.
        @(negedge clk);
        st = 1'b1; mplier = 32'd7; mcand = 32'd9;
        @(posedge clk);
        @(negedge clk);
        st = 1'b0;
        repeat (4) @(negedge clk);
        check("midrun_busy_before", 64'(busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check("midrun_busy", 64'(busy), 64'd0);
        check("midrun_load", 64'(load), 64'd1);
        check("midrun_hi",   64'(hi),   64'd0);
        check("midrun_lo",   64'(lo),   64'd0);
        check("midrun_done", 64'(done), 64'd0);
        rst = 1'b0;
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) pulses++;
        end
        check("midrun_no_activity", 64'(pulses), 64'd0);

        // Back-to-back with St held high.
        @(negedge clk);
        st = 1'b1; mplier = 32'd2; mcand = 32'd3;
        edges = 0;
        while (!done && edges < 100) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        check("b2b_first_latency", 64'(edges), 64'(W + 2));
        check("b2b_first_lo", 64'(lo), 64'd6);
        mplier = 32'd4; mcand = 32'd5;
        d = 0;
        do begin
            @(posedge clk);
            d++;
            @(negedge clk);
            if (d == 1) begin
                check("b2b_gap_busy", 64'(busy), 64'd0);
                check("b2b_gap_lo", 64'(lo), 64'd6);
                check("b2b_gap_hi", 64'(hi), 64'd0);
            end
        end while (!done && d < 100);
        check("b2b_spacing", 64'(d), 64'(W + 3));
        check("b2b_second_lo", 64'(lo), 64'd20);
        check("b2b_second_hi", 64'(hi), 64'd0);
        st = 1'b0;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
